// File: rtl/cell_sweep_ctrl.sv
// Gray-code stimulus sequencer for the standard-cell test block.
// It compacts each sampled response into a 32-bit MISR and compares the final signature with GOLDEN.
module cell_sweep_ctrl #(
  parameter int          IN_W   = 6,
  parameter int          OUT_W  = 73,
  parameter int          SETTLE = 2,
  parameter int          PASSES = 2,
  parameter logic [31:0] SEED   = 32'hFFFFFFFF,
  parameter logic [31:0] GOLDEN = 32'h00000000,
  localparam int         PW     = $clog2(PASSES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      signature,
  output logic [IN_W-1:0]  step_idx,
  output logic [PW-1:0]    pass_idx,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int              CW        = $clog2(SETTLE + 2);
  localparam logic [IN_W-1:0] LAST_STEP = '1;
  localparam logic [PW-1:0]   LAST_PASS = PW'(PASSES - 1);

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic            launch;
  logic            last_step;
  logic [95:0]     resp_ext;
  logic [31:0]     fold;
  logic [31:0]     misr_next;

  // start and abort are levels, not handshakes.
  // start is honoured only in IDLE or DONE, and abort overrides start in the same cycle.
  assign launch    = start && !abort && (state == S_IDLE || state == S_DONE);
  assign last_step = (step_idx == LAST_STEP) && (pass_idx == LAST_PASS);
  assign pass      = done && (signature == GOLDEN);
  assign dbg_state = state;

  always_comb begin
    resp_ext              = '0;
    resp_ext[OUT_W-1:0]   = resp;
    fold                  = resp_ext[31:0] ^ resp_ext[63:32] ^ resp_ext[95:64];
    misr_next             = {signature[30:0], 1'b0} ^ (signature[31] ? 32'h04C11DB7 : 32'h0) ^ fold;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (launch) state_next = S_DRIVE;
      S_DRIVE:        state_next = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
      S_SETTLE:       if (cnt == CW'(SETTLE - 1)) state_next = S_SAMPLE;
      S_SAMPLE:       state_next = last_step ? S_DONE : S_DRIVE;
      default:        state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      stim      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      signature <= SEED;
      step_idx  <= '0;
      pass_idx  <= '0;
      cnt       <= '0;
    end else begin
      state <= state_next;
      if (abort) begin
        // An aborted run leaves the partial signature visible for debug.
        if (state != S_IDLE) begin
          stim     <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
          step_idx <= '0;
          pass_idx <= '0;
        end
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              busy      <= 1'b1;
              done      <= 1'b0;
              signature <= SEED;
              step_idx  <= '0;
              pass_idx  <= '0;
            end
          end
          S_DRIVE: begin
            stim <= step_idx ^ (step_idx >> 1);
            cnt  <= '0;
          end
          S_SETTLE: cnt <= cnt + 1'b1;
          S_SAMPLE: begin
            signature <= misr_next;
            step_idx  <= step_idx + 1'b1;
            if (step_idx == LAST_STEP) pass_idx <= pass_idx + 1'b1;
            if (last_step) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cell_sweep_ctrl.sv
// Bench for cell_sweep_ctrl: a default instance with a randomized response table, two instances with a zero response, and a minimal 1-bit sweep.
// Expected values come from arithmetic on cycle and step counts.
module tb_cell_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd2;

  // default configuration, response from a random lookup on stim
  logic        start_a, abort_a;
  logic [5:0]  stim_a, step_a;
  logic [72:0] resp_a;
  logic        busy_a, done_a, pass_a;
  logic [31:0] sig_a;
  logic [1:0]  pidx_a;
  logic [2:0]  st_a;
  logic [72:0] lut [64];
  assign resp_a = lut[stim_a];

  cell_sweep_ctrl u_dflt (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .stim(stim_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .step_idx(step_a),
    .pass_idx(pidx_a), .dbg_state(st_a)
  );

  // SEED = 0 with resp tied to zero, GOLDEN 0 and 1
  logic        start_z, abort_z;
  logic [72:0] resp_z;
  logic [5:0]  stim_z0, stim_z1, step_z0, step_z1;
  logic        busy_z0, busy_z1, done_z0, done_z1, pass_z0, pass_z1;
  logic [31:0] sig_z0, sig_z1;
  logic [1:0]  pidx_z0, pidx_z1;
  logic [2:0]  st_z0, st_z1;

  cell_sweep_ctrl #(.SEED(32'h0), .GOLDEN(32'h0)) u_zero_g0 (
    .clk(clk), .rst(rst), .start(start_z), .abort(abort_z), .stim(stim_z0), .resp(resp_z),
    .busy(busy_z0), .done(done_z0), .pass(pass_z0), .signature(sig_z0), .step_idx(step_z0),
    .pass_idx(pidx_z0), .dbg_state(st_z0)
  );
  cell_sweep_ctrl #(.SEED(32'h0), .GOLDEN(32'h1)) u_zero_g1 (
    .clk(clk), .rst(rst), .start(start_z), .abort(abort_z), .stim(stim_z1), .resp(resp_z),
    .busy(busy_z1), .done(done_z1), .pass(pass_z1), .signature(sig_z1), .step_idx(step_z1),
    .pass_idx(pidx_z1), .dbg_state(st_z1)
  );

  // minimal sweep: IN_W 1, one pass, no settle, resp = 1
  logic        start_s, abort_s;
  logic [72:0] resp_s;
  logic [0:0]  stim_s, step_s, pidx_s;
  logic        busy_s, done_s, pass_s;
  logic [31:0] sig_s;
  logic [2:0]  st_s;

  cell_sweep_ctrl #(.IN_W(1), .PASSES(1), .SETTLE(0), .SEED(32'h0)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .stim(stim_s), .resp(resp_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .signature(sig_s), .step_idx(step_s),
    .pass_idx(pidx_s), .dbg_state(st_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] gray(input int n);
    logic [5:0] b;
    b = 6'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [72:0] r);
    logic [95:0] e;
    e = '0;
    e[72:0] = r;
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ e[31:0] ^ e[63:32] ^ e[95:64];
  endfunction

  // Start a default run and follow it for len edges after the start edge.
  // A stray start is raised mid-run and must be ignored.
  task automatic run_default(input int len, output logic [31:0] sig_out);
    logic [31:0] sig;
    logic [5:0]  prev;
    int          step;
    sig = 32'hFFFFFFFF;
    for (int i = 0; i < 64; i++) lut[i] = 73'({$urandom(), $urandom(), $urandom()});
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("busy_rise", busy_a, 1);
    check("done_clr", done_a, 0);
    check("sig_seed", sig_a, 32'hFFFFFFFF);
    prev = stim_a;
    for (int k = 1; k <= len; k++) begin
      start_a = (k == 200);
      tick();
      step = (k - 1) / 4;
      check("stim", stim_a, gray(step % 64));
      if ((k % 4) == 1 && k > 1) check("one_bit", $countones(stim_a ^ prev), 1);
      if ((k % 4) == 1) prev = stim_a;
      if ((k % 4) == 0) begin
        sig = misr(sig, lut[gray(step % 64)]);
        check("sig_step", sig_a, sig);
      end
      if (k < 512) begin
        check("busy_run", busy_a, 1);
        check("done_run", done_a, 0);
        check("pass_run", pass_a, 0);
        check("step_idx", step_a, (k / 4) % 64);
        check("pass_idx", pidx_a, (k / 4) / 64);
      end
    end
    start_a = 1'b0;
    if (len == 512) begin
      check("done_end", done_a, 1);
      check("busy_end", busy_a, 0);
      check("sig_end", sig_a, sig);
      check("pass_end", pass_a, (sig == 32'h0));
      check("pidx_end", pidx_a, 2);
    end
    sig_out = sig;
  endtask

  initial begin
    logic [31:0] s;
    rst = 1'b1;
    start_a = 0; abort_a = 0; start_z = 0; abort_z = 0; start_s = 0; abort_s = 0;
    resp_z = '0;
    resp_s = 73'h1;
    for (int i = 0; i < 64; i++) lut[i] = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_stim", stim_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_sig", sig_a, 32'hFFFFFFFF);
    check("rst_step", step_a, 0);
    check("rst_pidx", pidx_a, 0);
    check("rst_state", st_a, ST_IDLE);

    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("idle_abort_st", st_a, ST_IDLE);
    check("idle_abort_sig", sig_a, 32'hFFFFFFFF);

    // minimal sweep: two 2-cycle steps
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    check("s_busy", busy_s, 1);
    tick();
    check("s_stim0", stim_s, 0);
    tick();
    check("s_sig0", sig_s, 32'h1);
    tick();
    check("s_stim1", stim_s, 1);
    check("s_done3", done_s, 0);
    tick();
    check("s_done4", done_s, 1);
    check("s_busy4", busy_s, 0);
    check("s_sig_end", sig_s, 32'h3);
    check("s_pass", pass_s, 0);

    // zero response
    start_z = 1'b1;
    tick();
    start_z = 1'b0;
    for (int k = 1; k <= 512; k++) begin
      tick();
      if (k == 256) check("z_pass_mid", pass_z0, 0);
      if (k == 511) check("z_done_511", done_z0, 0);
    end
    check("z0_done", done_z0, 1);
    check("z0_sig", sig_z0, 32'h0);
    check("z0_pass", pass_z0, 1);
    check("z1_done", done_z1, 1);
    check("z1_sig", sig_z1, 32'h0);
    check("z1_pass", pass_z1, 0);

    // default full run, then DONE hold, then restart from DONE
    run_default(512, s);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_done", done_a, 1);
      check("hold_stim", stim_a, 6'b100000);
      check("hold_sig", sig_a, s);
    end
    run_default(512, s);

    // abort at cycle 100 together with start
    run_default(99, s);
    abort_a = 1'b1;
    start_a = 1'b1;
    tick();
    abort_a = 1'b0;
    start_a = 1'b0;
    check("ab_state", st_a, ST_IDLE);
    check("ab_stim", stim_a, 0);
    check("ab_busy", busy_a, 0);
    check("ab_done", done_a, 0);
    check("ab_step", step_a, 0);
    check("ab_pidx", pidx_a, 0);
    check("ab_sig", sig_a, s);
    tick();
    tick();
    check("ab_no_start", busy_a, 0);
    run_default(512, s);

    // reset while settling
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    check("pre_rst_state", st_a, ST_SETTLE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_state", st_a, ST_IDLE);
    check("mrst_stim", stim_a, 0);
    check("mrst_busy", busy_a, 0);
    check("mrst_done", done_a, 0);
    check("mrst_sig", sig_a, 32'hFFFFFFFF);
    check("mrst_step", step_a, 0);
    check("mrst_pidx", pidx_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
